trng_word_collector: RTL and testbench

- Downstream consumer of the TRNG core's 1-bit output stream. Accepts one raw bit per cycle when the core's valid is high.
- Runs a repetition-count health test (RCT) on the raw bits, discards a warm-up prefix, and packs accepted bits into WORD_W-bit words.
- Buffers words in a small first-word-fall-through (FWFT) FIFO with a valid/ready interface toward the bus or conditioner.

---
 rtl/trng_word_collector.sv | 174 +++++++++++++++++
 tb/tb_trng_word_collector.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/trng_word_collector.sv
// rtl/trng_word_collector.sv - TRNG raw-bit collector: RCT health test, warm-up discard, word packer, FWFT FIFO.
// Optional von Neumann debiasing between RCT and packer when VN_DEBIAS_EN is defined.
module trng_word_collector #(
   parameter int WORD_W      = 32,
   parameter int FIFO_DEPTH  = 4,
   parameter int RCT_CUTOFF  = 32,
   parameter int WARMUP_BITS = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   input  logic              i_bit,
   output logic [WORD_W-1:0] o_data,
   output logic              o_data_valid,
   input  logic              i_data_ready,
   output logic              o_health_fail,
   input  logic              i_clear_fail,
   output logic              o_overflow
);

   localparam int RUN_W  = $clog2(RCT_CUTOFF + 1);
   localparam int WARM_W = $clog2(WARMUP_BITS + 1);
   localparam int BIT_W  = $clog2(WORD_W);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(RCT_CUTOFF);
   localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_WARMUP, ST_COLLECT, ST_FAIL} state_t;

   state_t             state_q;
   logic [RUN_W-1:0]   run_q, run_d;
   logic               last_q;
   logic [WARM_W-1:0]  warm_q;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic [BIT_W-1:0]   bitcnt_q;
   logic               overflow_q;

   logic [WORD_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_q, wr_q;
   logic [CNT_W-1:0]   cnt_q;

   logic accept, rct_fail, collect_acc, pk_valid, pk_bit, push_d;
   logic fifo_empty, fifo_full, pop, push_ok;

`ifdef VN_DEBIAS_EN
   logic phase_q, first_q;
`endif

   assign accept = i_valid && (state_q != ST_FAIL);

   // run_q == 0 marks "no bit seen since reset/clear", so the first bit always starts a fresh run.
   always_comb begin
      run_d = run_q;
      if (accept) begin
         if ((run_q != '0) && (i_bit == last_q)) run_d = run_q + RUN_W'(1);
         else                                    run_d = RUN_W'(1);
      end
   end

   assign rct_fail    = accept && (run_d == RUN_MAX);
   assign collect_acc = accept && (state_q == ST_COLLECT) && !rct_fail;

`ifdef VN_DEBIAS_EN
   assign pk_valid = collect_acc && phase_q && (first_q != i_bit);
   assign pk_bit   = first_q;
`else
   assign pk_valid = collect_acc;
   assign pk_bit   = i_bit;
`endif

   assign shift_d = {shift_q[WORD_W-2:0], pk_bit};
   assign push_d  = pk_valid && (bitcnt_q == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_WARMUP;
         run_q    <= '0;
         last_q   <= 1'b0;
         warm_q   <= '0;
         shift_q  <= '0;
         bitcnt_q <= '0;
`ifdef VN_DEBIAS_EN
         phase_q  <= 1'b0;
         first_q  <= 1'b0;
`endif
      end else begin
         run_q <= run_d;
         if (accept) last_q <= i_bit;
         case (state_q)
            ST_WARMUP: begin
               if (rct_fail) begin
                  state_q  <= ST_FAIL;
                  shift_q  <= '0;
                  bitcnt_q <= '0;
               end else if (accept) begin
                  if (warm_q == WARM_LAST) begin
                     state_q <= ST_COLLECT;
`ifdef VN_DEBIAS_EN
                     phase_q <= 1'b0;
`endif
                  end else begin
                     warm_q <= warm_q + WARM_W'(1);
                  end
               end
            end
            ST_COLLECT: begin
               if (rct_fail) begin
                  state_q  <= ST_FAIL;
                  shift_q  <= '0;
                  bitcnt_q <= '0;
`ifdef VN_DEBIAS_EN
                  phase_q  <= 1'b0;
`endif
               end else begin
`ifdef VN_DEBIAS_EN
                  if (collect_acc) begin
                     phase_q <= ~phase_q;
                     first_q <= i_bit;
                  end
`endif
                  if (pk_valid) begin
                     shift_q  <= shift_d;
                     bitcnt_q <= push_d ? '0 : bitcnt_q + BIT_W'(1);
                  end
               end
            end
            ST_FAIL: begin
               if (i_clear_fail) begin
                  state_q <= ST_WARMUP;
                  run_q   <= '0;
                  last_q  <= 1'b0;
                  warm_q  <= '0;
               end
            end
            default: state_q <= ST_WARMUP;
         endcase
      end
   end

   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == FIFO_FULL);
   assign pop        = !fifo_empty && i_data_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is only dropped without one.
   assign push_ok    = push_d && (!fifo_full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= shift_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q       <= '0;
         wr_q       <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_q <= wr_q + PTR_W'(1);
         if (pop)     rd_q <= rd_q + PTR_W'(1);
         if (push_ok && !pop)      cnt_q <= cnt_q + CNT_W'(1);
         else if (pop && !push_ok) cnt_q <= cnt_q - CNT_W'(1);
         if (push_d && !push_ok) overflow_q <= 1'b1;
      end
   end

   assign o_data        = fifo_empty ? '0 : mem_q[rd_q];
   assign o_data_valid  = !fifo_empty;
   assign o_health_fail = (state_q == ST_FAIL);
   assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_trng_word_collector.sv
// tb/tb_trng_word_collector.sv - self-checking bench for trng_word_collector against a bit-history reference model.
module tb_trng_word_collector;

   localparam int WW    = 8;
   localparam int DEPTH = 2;
   localparam int RCT   = 8;
   localparam int WARM  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_valid = 1'b0;
   logic          i_bit = 1'b0;
   logic          i_data_ready = 1'b0;
   logic          i_clear_fail = 1'b0;
   logic [WW-1:0] o_data;
   logic          o_data_valid;
   logic          o_health_fail;
   logic          o_overflow;

   int n_checks = 0;
   int n_errors = 0;

   logic       m_hist[$];
   logic       m_pack[$];
   logic [7:0] m_fifo[$];
   logic       m_fail;
   logic       m_ovf;

   trng_word_collector #(
      .WORD_W(WW), .FIFO_DEPTH(DEPTH), .RCT_CUTOFF(RCT), .WARMUP_BITS(WARM)
   ) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_bit(i_bit),
      .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
      .o_health_fail(o_health_fail), .i_clear_fail(i_clear_fail), .o_overflow(o_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      m_pack.delete();
      m_fifo.delete();
      m_fail = 1'b0;
      m_ovf  = 1'b0;
   endtask

   // Reference: RCT is the trailing run of the raw-bit history since reset/clear;
   // history positions beyond WARM are the collected bits.
   task automatic model_step(input logic v, input logic b, input logic r, input logic c);
      logic       push;
      logic [7:0] w;
      int         run;
      logic       do_pop;
      do_pop = (m_fifo.size() != 0) && r;
      push = 1'b0;
      w = '0;
      if (m_fail) begin
         if (c) begin
            m_fail = 1'b0;
            m_hist.delete();
         end
      end else if (v) begin
         m_hist.push_back(b);
         run = 0;
         for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i] != b) break;
            run++;
         end
         if (run >= RCT) begin
            m_fail = 1'b1;
            m_pack.delete();
         end else if (m_hist.size() > WARM) begin
`ifdef VN_DEBIAS_EN
            if (((m_hist.size() - WARM) % 2 == 0) && (m_hist[m_hist.size()-2] != b))
               m_pack.push_back(m_hist[m_hist.size()-2]);
`else
            m_pack.push_back(b);
`endif
            if (m_pack.size() == WW) begin
               foreach (m_pack[i]) w = {w[6:0], m_pack[i]};
               push = 1'b1;
               m_pack.delete();
            end
         end
      end
      if (do_pop) void'(m_fifo.pop_front());
      if (push) begin
         if (m_fifo.size() < DEPTH) m_fifo.push_back(w);
         else m_ovf = 1'b1;
      end
   endtask

   task automatic cycle(input logic v, input logic b, input logic r, input logic c);
      i_valid = v;
      i_bit = b;
      i_data_ready = r;
      i_clear_fail = c;
      @(posedge clk);
      model_step(v, b, r, c);
      #1;
      chk("valid", {31'd0, o_data_valid}, {31'd0, m_fifo.size() != 0});
      chk("data", {24'd0, o_data}, (m_fifo.size() != 0) ? {24'd0, m_fifo[0]} : 32'd0);
      chk("health", {31'd0, o_health_fail}, {31'd0, m_fail});
      chk("ovf", {31'd0, o_overflow}, {31'd0, m_ovf});
   endtask

   task automatic feed(input logic [31:0] bits, input int n, input logic r, input logic toggle);
      for (int i = n - 1; i >= 0; i--) begin
         cycle(1'b1, bits[i], r, 1'b0);
         if (toggle) cycle(1'b0, 1'($urandom_range(0, 1)), r, 1'b0);
      end
   endtask

   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", {31'd0, o_data_valid}, 32'd0);
      chk("rst_data", {24'd0, o_data}, 32'd0);
      chk("rst_health", {31'd0, o_health_fail}, 32'd0);
      chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
      model_reset();
      i_valid = 1'b0;
      i_clear_fail = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   logic prev_bit;

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // Test 1: async reset with a word buffered, then warm-up needed again.
      feed(32'h5, 4, 1'b0, 1'b0);
      feed(32'hB2, 8, 1'b0, 1'b0);
      chk("t1_buffered", {31'd0, o_data_valid}, 32'd1);
      do_reset();
      feed(32'hB2, 8, 1'b0, 1'b0);
      chk("t1_no_word_yet", {31'd0, o_data_valid}, 32'd0);
      feed(32'h5, 4, 1'b0, 1'b0);
      chk("t1_word_after_warm", {31'd0, o_data_valid}, 32'd1);

      // Test 2: latency and value of the first word.
      do_reset();
      feed(32'h5, 4, 1'b1, 1'b0);
      feed(32'h59, 7, 1'b1, 1'b0);
      chk("t2_pre_valid", {31'd0, o_data_valid}, 32'd0);
      feed(32'h0, 1, 1'b1, 1'b0);
      chk("t2_valid", {31'd0, o_data_valid}, 32'd1);
      chk("t2_data", {24'd0, o_data}, 32'hB2);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_popped", {31'd0, o_data_valid}, 32'd0);

      // Test 3: gapped valid gives the same word.
      do_reset();
      feed(32'h5, 4, 1'b0, 1'b1);
      feed(32'hB2, 8, 1'b0, 1'b1);
      chk("t3_data", {24'd0, o_data}, 32'hB2);

      // Test 4: overflow with ready low, then drain.
      do_reset();
      feed(32'hA, 4, 1'b0, 1'b0);
      feed(32'h5A, 8, 1'b0, 1'b0);
      feed(32'hA5, 8, 1'b0, 1'b0);
      chk("t4_no_ovf_yet", {31'd0, o_overflow}, 32'd0);
      feed(32'h3C, 8, 1'b0, 1'b0);
      chk("t4_ovf", {31'd0, o_overflow}, 32'd1);
      chk("t4_head", {24'd0, o_data}, 32'h5A);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_second", {24'd0, o_data}, 32'hA5);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t4_empty", {31'd0, o_data_valid}, 32'd0);
      chk("t4_ovf_sticky", {31'd0, o_overflow}, 32'd1);

      // Test 5: RCT failure, ignored bits, clear, warm-up again.
      do_reset();
      feed(32'hA, 4, 1'b0, 1'b0);
      feed(32'h5A, 8, 1'b0, 1'b0);
      feed(32'h7F, 8, 1'b0, 1'b0);
      chk("t5_no_fail_yet", {31'd0, o_health_fail}, 32'd0);
      feed(32'h1, 1, 1'b0, 1'b0);
      chk("t5_fail", {31'd0, o_health_fail}, 32'd1);
      feed(32'hC3, 8, 1'b0, 1'b0);
      chk("t5_fifo_kept", {24'd0, o_data}, 32'h5A);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_cleared", {31'd0, o_health_fail}, 32'd0);
      feed(32'h5, 4, 1'b1, 1'b0);
      chk("t5_warm_popped", {31'd0, o_data_valid}, 32'd0);
      feed(32'hB2, 8, 1'b1, 1'b0);
      chk("t5_new_word", {24'd0, o_data}, 32'hB2);

`ifdef VN_DEBIAS_EN
      // Test 6: von Neumann pairs.
      do_reset();
      feed(32'hA, 4, 1'b0, 1'b0);
      feed(32'h6C, 8, 1'b0, 1'b0);
      feed(32'hA5, 8, 1'b0, 1'b0);
      feed(32'h9, 4, 1'b0, 1'b0);
      chk("t6_vn_word", {24'd0, o_data}, 32'h72);
`endif

      // Randomized run with biased bits to exercise RCT failures.
      do_reset();
      prev_bit = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic v, b, r, c;
         v = ($urandom_range(0, 3) != 0);
         b = ($urandom_range(0, (i % 600 < 300) ? 1 : 4) == 0) ? ~prev_bit : prev_bit;
         prev_bit = b;
         r = ($urandom_range(0, (i % 1000 < 500) ? 1 : 5) == 0);
         c = m_fail ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
         cycle(v, b, r, c);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
